// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment display.
// Holds the active-high hex glyphs (bit 6 = G ... bit 0 = A), the blank glyph
// and the digit-slot state encoding.
package seg_pkg;

  typedef enum logic [0:0] {
    StOn    = 1'b0,
    StBlank = 1'b1
  } slot_state_e;

  localparam logic [6:0] GlyphBlank = 7'h00;
  localparam logic [6:0] Glyph0     = 7'h3F;
  localparam logic [6:0] Glyph1     = 7'h06;
  localparam logic [6:0] Glyph2     = 7'h5B;
  localparam logic [6:0] Glyph3     = 7'h4F;
  localparam logic [6:0] Glyph4     = 7'h66;
  localparam logic [6:0] Glyph5     = 7'h6D;
  localparam logic [6:0] Glyph6     = 7'h7D;
  localparam logic [6:0] Glyph7     = 7'h07;
  localparam logic [6:0] Glyph8     = 7'h7F;
  localparam logic [6:0] Glyph9     = 7'h6F;
  localparam logic [6:0] GlyphA     = 7'h77;
  localparam logic [6:0] GlyphB     = 7'h7C;  // lowercase b
  localparam logic [6:0] GlyphC     = 7'h39;
  localparam logic [6:0] GlyphD     = 7'h5E;  // lowercase d
  localparam logic [6:0] GlyphE     = 7'h79;
  localparam logic [6:0] GlyphF     = 7'h71;

endpackage

// File: rtl/hex_glyph_decoder.sv
// Registered hex-to-seven-segment decoder.
// Ports: clk_i / rst_ni (async active-low), nibble_i (hex digit),
//        glyph_o (active-high G..A glyph, one cycle after nibble_i).
module hex_glyph_decoder
  import seg_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] nibble_i,
  output logic [6:0] glyph_o
);

  logic [6:0] glyph_d, glyph_q;

  always_comb begin
    glyph_d = GlyphBlank;
    unique case (nibble_i)
      4'h0: glyph_d = Glyph0;
      4'h1: glyph_d = Glyph1;
      4'h2: glyph_d = Glyph2;
      4'h3: glyph_d = Glyph3;
      4'h4: glyph_d = Glyph4;
      4'h5: glyph_d = Glyph5;
      4'h6: glyph_d = Glyph6;
      4'h7: glyph_d = Glyph7;
      4'h8: glyph_d = Glyph8;
      4'h9: glyph_d = Glyph9;
      4'hA: glyph_d = GlyphA;
      4'hB: glyph_d = GlyphB;
      4'hC: glyph_d = GlyphC;
      4'hD: glyph_d = GlyphD;
      4'hE: glyph_d = GlyphE;
      4'hF: glyph_d = GlyphF;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      glyph_q <= GlyphBlank;
    end else begin
      glyph_q <= glyph_d;
    end
  end

  assign glyph_o = glyph_q;

endmodule

// File: rtl/multi_digit_display.sv
// Multiplexed hex display driver with shadow/display double buffering,
// leading-zero blanking and PWM brightness.
// Ports: i_clk, i_rst_n (async active-low); i_data/i_dp captured on i_load into
// a shadow register, committed at the frame boundary; i_blank_lz, i_brightness
// shape the output; o_segments (G..A), o_dp, o_digit_en (one-hot), o_pending.
// Pipeline: display register / digit index -> stage 1 (glyph + qualifiers)
// -> output register with polarity, i.e. two cycles to the pins.
module multi_digit_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned CLK_HZ           = 48_000_000,
  parameter int unsigned SCAN_HZ          = 1000,
  parameter int unsigned ON_TICKS         = 3,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_load,
  input  logic                    i_blank_lz,
  input  logic [3:0]              i_brightness,
  output logic [6:0]              o_segments,
  output logic                    o_dp,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_pending
);

  localparam int unsigned Prescale = CLK_HZ / SCAN_HZ;
  localparam int unsigned PreW     = (Prescale > 1) ? $clog2(Prescale) : 1;
  localparam int unsigned IdxW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned OnW      = (ON_TICKS > 1) ? $clog2(ON_TICKS) : 1;

  localparam logic [6:0]            SegOff   = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DigitOff = {NUM_DIGITS{DIGIT_ACTIVE_LOW}};

  // Scan prescaler
  logic [PreW-1:0] presc_d, presc_q;
  logic            tick;

  assign tick = (presc_q == '0);

  always_comb begin
    presc_d = tick ? PreW'(Prescale - 1) : presc_q - 1'b1;
  end

  // Digit slot FSM
  slot_state_e     state_d, state_q;
  logic [IdxW-1:0] idx_d, idx_q;
  logic [OnW-1:0]  on_cnt_d, on_cnt_q;
  logic            idx_last;
  logic            slot_on;
  logic            frame_end;

  assign idx_last = (idx_q == IdxW'(NUM_DIGITS - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    on_cnt_d = on_cnt_q;
    if (tick) begin
      unique case (state_q)
        StOn: begin
          if (on_cnt_q == OnW'(ON_TICKS - 1)) begin
            state_d  = StBlank;
            on_cnt_d = '0;
          end else begin
            on_cnt_d = on_cnt_q + 1'b1;
          end
        end
        StBlank: begin
          state_d = StOn;
          idx_d   = idx_last ? '0 : idx_q + 1'b1;
        end
        default: state_d = StOn;
      endcase
    end
  end

  always_comb begin
    slot_on   = (state_q == StOn);
    // Tick that wraps the index back to digit 0: the only safe commit point.
    frame_end = tick && (state_q == StBlank) && idx_last;
  end

  // Shadow and display registers
  logic [4*NUM_DIGITS-1:0] shadow_d, shadow_q, disp_d, disp_q;
  logic [NUM_DIGITS-1:0]   sdp_d, sdp_q, ddp_d, ddp_q;
  logic                    pending_d, pending_q;

  always_comb begin
    shadow_d  = shadow_q;
    sdp_d     = sdp_q;
    disp_d    = disp_q;
    ddp_d     = ddp_q;
    pending_d = pending_q;
    if (i_load) begin
      shadow_d  = i_data;
      sdp_d     = i_dp;
      pending_d = 1'b1;
    end
    // Committing shadow_d lets a load on the commit tick go straight through.
    if (frame_end) begin
      disp_d    = shadow_d;
      ddp_d     = sdp_d;
      pending_d = 1'b0;
    end
  end

  // Current digit selection and leading-zero detection
  logic [3:0]            cur_nibble;
  logic                  cur_dp;
  logic [NUM_DIGITS-1:0] cur_onehot;
  logic                  upper_zero;
  logic                  lz_blank;

  always_comb begin
    cur_nibble = '0;
    cur_dp     = 1'b0;
    cur_onehot = '0;
    upper_zero = 1'b1;
    lz_blank   = 1'b0;
    // Walk from the most significant digit down; upper_zero holds while all
    // nibbles seen so far (including this one) are zero.
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_q[4*k +: 4] == 4'h0);
      if (idx_q == IdxW'(k)) begin
        cur_nibble    = disp_q[4*k +: 4];
        cur_dp        = ddp_q[k];
        cur_onehot[k] = 1'b1;
        lz_blank      = (k != 0) && upper_zero;
      end
    end
    lz_blank = lz_blank && i_blank_lz;
  end

  // PWM and stage-1 qualifiers
  logic [3:0]            pwm_d, pwm_q;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] en_s1_d, en_s1_q;
  logic                  seg_lit_s1_d, seg_lit_s1_q;
  logic                  dp_lit_s1_d, dp_lit_s1_q;
  logic [6:0]            glyph;

  always_comb begin
    pwm_d        = pwm_q + 4'd1;
    pwm_on       = (pwm_q < i_brightness);
    en_s1_d      = slot_on ? cur_onehot : '0;
    seg_lit_s1_d = slot_on && pwm_on && !lz_blank;
    dp_lit_s1_d  = slot_on && pwm_on && cur_dp;
  end

  hex_glyph_decoder u_decoder (
    .clk_i    (i_clk),
    .rst_ni   (i_rst_n),
    .nibble_i (cur_nibble),
    .glyph_o  (glyph)
  );

  // Output register, polarity applied here only
  logic [6:0]            seg_out_d, seg_out_q;
  logic                  dp_out_d, dp_out_q;
  logic [NUM_DIGITS-1:0] en_out_d, en_out_q;

  always_comb begin
    seg_out_d = (seg_lit_s1_q ? glyph : GlyphBlank) ^ SegOff;
    dp_out_d  = dp_lit_s1_q ^ SEG_ACTIVE_LOW;
    en_out_d  = en_s1_q ^ DigitOff;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q      <= PreW'(Prescale - 1);
      state_q      <= StOn;
      idx_q        <= '0;
      on_cnt_q     <= '0;
      shadow_q     <= '0;
      sdp_q        <= '0;
      disp_q       <= '0;
      ddp_q        <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= '0;
      en_s1_q      <= '0;
      seg_lit_s1_q <= 1'b0;
      dp_lit_s1_q  <= 1'b0;
      seg_out_q    <= SegOff;
      dp_out_q     <= SEG_ACTIVE_LOW;
      en_out_q     <= DigitOff;
    end else begin
      presc_q      <= presc_d;
      state_q      <= state_d;
      idx_q        <= idx_d;
      on_cnt_q     <= on_cnt_d;
      shadow_q     <= shadow_d;
      sdp_q        <= sdp_d;
      disp_q       <= disp_d;
      ddp_q        <= ddp_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      en_s1_q      <= en_s1_d;
      seg_lit_s1_q <= seg_lit_s1_d;
      dp_lit_s1_q  <= dp_lit_s1_d;
      seg_out_q    <= seg_out_d;
      dp_out_q     <= dp_out_d;
      en_out_q     <= en_out_d;
    end
  end

  assign o_segments = seg_out_q;
  assign o_dp       = dp_out_q;
  assign o_digit_en = en_out_q;
  assign o_pending  = pending_q;

endmodule

// File: tb/tb_multi_digit_display.sv
// Bench for multi_digit_display with 4 digits, prescale 4, 3 ON ticks.
// Reference: absolute cycle count c since reset release gives the scan
// position (64-cycle frame, 16 cycles per digit, first 12 lit), pins lag by 2.
module tb_multi_digit_display;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_data = '0;
  logic [3:0]  i_dp = '0;
  logic        i_load = 1'b0;
  logic        i_blank_lz = 1'b0;
  logic [3:0]  i_brightness = 4'hF;
  logic [6:0]  o_segments;
  logic        o_dp;
  logic [3:0]  o_digit_en;
  logic        o_pending;

  multi_digit_display #(
    .NUM_DIGITS       (4),
    .CLK_HZ           (16),
    .SCAN_HZ          (4),
    .ON_TICKS         (3),
    .SEG_ACTIVE_LOW   (1'b1),
    .DIGIT_ACTIVE_LOW (1'b0)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_dp         (i_dp),
    .i_load       (i_load),
    .i_blank_lz   (i_blank_lz),
    .i_brightness (i_brightness),
    .o_segments   (o_segments),
    .o_dp         (o_dp),
    .o_digit_en   (o_digit_en),
    .o_pending    (o_pending)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int unsigned c;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend;
  logic [6:0]  s1_seg, exp_seg;
  logic        s1_dp, exp_dp;
  logic [3:0]  s1_en, exp_en;
  logic [6:0]  glyph [16];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, c);
    end
  endtask

  task automatic model_reset();
    c = 0;
    m_disp = '0; m_shadow = '0; m_ddp = '0; m_sdp = '0; m_pend = 1'b0;
    s1_seg = 7'h7F; s1_dp = 1'b1; s1_en = 4'b0;
    exp_seg = 7'h7F; exp_dp = 1'b1; exp_en = 4'b0;
  endtask

  // Pins that the scan position of cycle c produces (appear two cycles later).
  task automatic model_pins(output logic [6:0] seg, output logic dpo, output logic [3:0] en);
    int dig;
    int w;
    bit on, bright, lz;
    dig    = int'((c % 64) / 16);
    w      = int'(c % 16);
    on     = (w < 12);
    bright = (w < int'(i_brightness));
    lz     = i_blank_lz && (dig != 0) && ((m_disp >> (4 * dig)) == 16'h0);
    en     = on ? 4'(1 << dig) : 4'b0;
    seg    = (on && bright && !lz) ? ~glyph[m_disp[4*dig +: 4]] : 7'h7F;
    dpo    = (on && bright && m_ddp[dig]) ? 1'b0 : 1'b1;
  endtask

  task automatic cyc();
    logic [6:0] nseg;
    logic       ndp;
    logic [3:0] nen;
    model_pins(nseg, ndp, nen);
    @(posedge i_clk);
    exp_seg = s1_seg; exp_dp = s1_dp; exp_en = s1_en;
    s1_seg = nseg; s1_dp = ndp; s1_en = nen;
    if (c % 64 == 63) begin
      if (i_load) begin
        m_shadow = i_data;
        m_sdp    = i_dp;
      end
      m_disp = m_shadow;
      m_ddp  = m_sdp;
      m_pend = 1'b0;
    end else if (i_load) begin
      m_shadow = i_data;
      m_sdp    = i_dp;
      m_pend   = 1'b1;
    end
    c++;
    #1;
    chk("segments", 16'(o_segments), 16'(exp_seg));
    chk("dp", 16'(o_dp), 16'(exp_dp));
    chk("digit_en", 16'(o_digit_en), 16'(exp_en));
    chk("pending", 16'(o_pending), 16'(m_pend));
  endtask

  task automatic run_to_phase(input int unsigned ph);
    while (c % 64 != ph) cyc();
  endtask

  task automatic wait_en(input logic [3:0] target, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc();
      if (o_digit_en === target) found = 1'b1;
    end
    chk("wait_digit_en", 16'(found), 16'h1);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    i_data = d; i_dp = dp; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
  endtask

  task automatic check_reset_pins(input string tag);
    chk({tag, "_seg"}, 16'(o_segments), 16'h007F);
    chk({tag, "_dp"}, 16'(o_dp), 16'h0001);
    chk({tag, "_en"}, 16'(o_digit_en), 16'h0000);
    chk({tag, "_pend"}, 16'(o_pending), 16'h0000);
  endtask

  initial begin
    int lit;
    logic [15:0] rd;
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();

    // Power-on reset
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_pins("por");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    wait_en(4'b0001, 4);
    repeat (100) cyc();

    // Load 12AF mid-frame: pending until boundary, then F on digit 0, 1 on digit 3
    run_to_phase(10);
    load(16'h12AF, 4'b0100);
    run_to_phase(0);
    wait_en(4'b0001, 8);
    chk("load_dig0", 16'(o_segments), 16'h000E);
    wait_en(4'b1000, 64);
    chk("load_dig3", 16'(o_segments), 16'h0079);
    repeat (40) cyc();

    // Leading-zero blanking with 0030
    i_blank_lz = 1'b1;
    run_to_phase(5);
    load(16'h0030, 4'b0000);
    run_to_phase(0);
    wait_en(4'b0001, 8);
    chk("lz_dig0", 16'(o_segments), 16'h0040);
    wait_en(4'b0010, 24);
    chk("lz_dig1", 16'(o_segments), 16'h0030);
    wait_en(4'b0100, 24);
    chk("lz_dig2", 16'(o_segments), 16'h007F);
    wait_en(4'b1000, 24);
    chk("lz_dig3", 16'(o_segments), 16'h007F);
    i_blank_lz = 1'b0;

    // Brightness: 0 never lit, 8 lit in 8 of each 16 clocks while ON
    load(16'h8888, 4'b0000);
    repeat (130) cyc();
    i_brightness = 4'd0;
    repeat (2) cyc();
    lit = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (o_segments !== 7'h7F) lit++;
    end
    chk("bri0_lit", 16'(lit), 16'd0);
    i_brightness = 4'd8;
    repeat (2) cyc();
    lit = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (o_segments !== 7'h7F) lit++;
    end
    chk("bri8_lit", 16'(lit), 16'd32);
    i_brightness = 4'hF;

    // Load coincident with the commit tick goes straight to the display
    run_to_phase(63);
    load(16'h5555, 4'b0001);
    chk("sim_pend", 16'(o_pending), 16'h0000);
    wait_en(4'b0001, 8);
    chk("sim_dig0", 16'(o_segments), 16'h0012);

    // Randomized loads (several per frame possible), blanking and brightness
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        i_blank_lz   = 1'($urandom_range(0, 1));
        i_brightness = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 4; k++) rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        load(rd, 4'($urandom));
      end else begin
        cyc();
      end
    end
    i_blank_lz = 1'b0;
    i_brightness = 4'hF;

    // Reset mid-scan with a load pending: display returns to zeros at digit 0
    run_to_phase(20);
    load(16'hBEEF, 4'b1111);
    repeat (5) cyc();
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_reset_pins("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    wait_en(4'b0001, 4);
    chk("midrst_dig0", 16'(o_segments), 16'h0040);
    repeat (140) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_digit_display.md
MULTI_DIGIT_DISPLAY -- requirements
Module: multi_digit_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter CLK_HZ, default 48_000_000, i_clk frequency.
REQ-003 SHALL have parameter SCAN_HZ, default 1000, scan tick rate.
REQ-004 SHALL have parameter ON_TICKS, default 3, lit ticks per digit slot (legal >=1).
REQ-005 SHALL have parameters SEG_ACTIVE_LOW, default 1, and DIGIT_ACTIVE_LOW, default 0, giving output polarity.
REQ-006 SHALL have port i_clk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port i_data  input  4*NUM_DIGITS  hex nibbles, nibble k drives digit k (digit 0 = least significant).
REQ-009 SHALL have port i_dp  input  NUM_DIGITS  decimal point per digit, active-high.
REQ-010 SHALL have port i_load  input  1  single-cycle strobe capturing i_data/i_dp into the shadow register.
REQ-011 SHALL have port i_blank_lz  input  1  leading-zero blanking enable.
REQ-012 SHALL have port i_brightness  input  4  PWM duty, 0 = dark, 15 = 15/16.
REQ-013 SHALL have port o_segments  output  7  segments G..A (msb = G).
REQ-014 SHALL have port o_dp  output  1  decimal point segment.
REQ-015 SHALL have port o_digit_en  output  NUM_DIGITS  one-hot digit select.
REQ-016 SHALL have port o_pending  output  1  shadow holds data not yet displayed.

Function
REQ-017 SHALL divide i_clk by PRESCALE = CLK_HZ/SCAN_HZ; down-counter reloads PRESCALE-1 on reaching 0, emitting a one-cycle tick.
REQ-018 SHALL run a per-digit slot FSM: ON for ON_TICKS ticks, then BLANK for 1 tick, then advance digit index, wrapping NUM_DIGITS-1 -> 0.
REQ-019 SHALL drive o_digit_en active only for the current digit in ON; all inactive in BLANK.
REQ-020 SHALL drive segments/dp inactive in BLANK, and in ON whenever free-running 4-bit pwm counter >= i_brightness.
REQ-021 SHALL set o_pending the cycle after i_load; last i_load wins when several arrive before commit.
REQ-022 SHALL commit shadow to display register on the tick where index wraps to 0 (frame boundary) and clear o_pending then; no tearing mid-frame.
REQ-023 SHALL, on i_load coincident with the commit tick, commit the incoming i_data/i_dp directly and leave o_pending low.
REQ-024 SHALL, when i_blank_lz=1, blank every digit from NUM_DIGITS-1 downward whose nibble is 0 until the first nonzero nibble; digit 0 never blanked; dp unaffected.
REQ-025 SHALL decode nibbles 0-F to standard hex glyphs (b, d lowercase) via a registered decoder; total pipeline latency from display register/index to pins is 2 cycles, fixed.
REQ-026 SHALL apply SEG_ACTIVE_LOW to o_segments and o_dp, DIGIT_ACTIVE_LOW to o_digit_en, at the output register only.

Reset
REQ-027 SHALL on i_rst_n low force o_segments/o_dp/o_digit_en inactive (per polarity), o_pending 0, display and shadow registers 0, digit index 0, FSM in ON, pwm counter 0, prescaler PRESCALE-1.
REQ-028 SHALL, after reset release mid-frame, restart at digit 0 with any pre-reset load discarded.

Structure
REQ-029 SHALL place glyph constants (hex 0-F, blank) and state encodings in shared package seg_pkg.
REQ-030 SHALL instantiate one sub-module hex_glyph_decoder (nibble in, registered 7-bit active-high glyph out).

Verification (NUM_DIGITS=4, CLK_HZ=16, SCAN_HZ=4, ON_TICKS=3, SEG_ACTIVE_LOW=1, DIGIT_ACTIVE_LOW=0, brightness 15)
REQ-031 SHALL check reset: i_rst_n=0 mid-scan -> o_segments=7'h7F, o_dp=1, o_digit_en=4'b0000 immediately; scan restarts at digit 0.
REQ-032 SHALL check load: i_load with i_data=16'h12AF -> o_pending=1 until the next frame boundary; then digit0 o_segments=7'h0E (F), digit3=7'h79 (1).
REQ-033 SHALL check timing: each digit ON exactly 12 clocks then 4 clocks all-inactive; frame = 64 clocks.
REQ-034 SHALL check LZ blanking: i_data=16'h0030, i_blank_lz=1 -> digits 3,2 o_segments=7'h7F, digit1=7'h30 (3), digit0=7'h40 (0).
REQ-035 SHALL check brightness: i_brightness=0 -> segments never lit while digits scan; =8 -> lit exactly 8 of each 16 ON clocks.
REQ-036 SHALL check simultaneous load at commit tick: data 16'h5555 on wrap cycle -> displayed that frame, o_pending stays 0.
